// File: rtl/hcsr04_scan_sched.sv
// Round-robin HC-SR04 ranging scheduler: one shared echo-timing engine
// fires N_SENS sensors in turn, times the selected echo in microseconds,
// publishes a tagged result per slot and keeps a per-sensor "near" mask.
`timescale 1ns/1ps
module hcsr04_scan_sched #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_SENS     = 4,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_US     = 60000,
    parameter int THRESH_US  = 1160,
    localparam int IDW       = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_SENS-1:0] echo_in,
    output logic [N_SENS-1:0] trig_out,
    output logic              meas_valid,
    output logic [IDW-1:0]    meas_id,
    output logic [15:0]       meas_us,
    output logic              meas_ok,
    output logic [N_SENS-1:0] near_mask,
    output logic              busy
);

    localparam int US_DIV = CLK_HZ / 1_000_000;
    localparam int DIV_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(US_DIV - 1);
    localparam logic [16:0]      TRIG_LAST = 17'(TRIG_US - 1);
    localparam logic [16:0]      TMO_T     = 17'(TIMEOUT_US);
    localparam logic [16:0]      GAP_T     = 17'(GAP_US);
    localparam logic [15:0]      THRESH_T  = 16'(THRESH_US);
    localparam logic [IDW-1:0]   SEL_LAST  = IDW'(N_SENS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_H,
        S_MEAS,
        S_GAP
    } state_t;

    // Clamp an internal 17-bit count to the published 16-bit range.
    function automatic logic [15:0] sat_us(input logic [16:0] v);
        sat_us = (v >= TMO_T) ? TMO_T[15:0] : v[15:0];
    endfunction

    // A sensor is near only for a real, non-zero echo within threshold.
    function automatic logic is_near(input logic ok, input logic [15:0] us);
        is_near = ok && (us != 16'd0) && (us <= THRESH_T);
    endfunction

    function automatic logic [N_SENS-1:0] onehot(input logic [IDW-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    logic [DIV_W-1:0]  div_q, div_d;
    logic [N_SENS-1:0] sync1_q, sync1_d;
    logic [N_SENS-1:0] sync2_q, sync2_d;
    state_t            state_q, state_d;
    logic [IDW-1:0]    sel_q, sel_d;
    logic [16:0]       t_q, t_d;
    logic [16:0]       w_q, w_d;
    logic              ep_q, ep_d;
    logic [N_SENS-1:0] trig_q, trig_d;
    logic              mv_q, mv_d;
    logic [IDW-1:0]    mid_q, mid_d;
    logic [15:0]       mus_q, mus_d;
    logic              mok_q, mok_d;
    logic [N_SENS-1:0] near_q, near_d;
    logic              busy_q, busy_d;

    logic              us_tick;
    logic              echo_cur;
    logic              pub;
    logic [15:0]       pub_us;
    logic              pub_ok;

    assign us_tick  = (div_q == DIV_LAST);
    assign echo_cur = sync2_q[sel_q];

    // Microsecond divider and two-stage echo synchronizers.
    always_comb begin
        div_d   = us_tick ? '0 : div_q + 1'b1;
        sync1_d = echo_in;
        sync2_d = sync1_q;
    end

    // Slot sequencer: every state change and counter step happens on a tick.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        t_d     = t_q;
        w_d     = w_q;
        ep_d    = ep_q;
        trig_d  = trig_q;
        mv_d    = 1'b0;
        mid_d   = mid_q;
        mus_d   = mus_q;
        mok_d   = mok_q;
        near_d  = near_q;
        pub     = 1'b0;
        pub_us  = '0;
        pub_ok  = 1'b0;

        if (us_tick) begin
            ep_d = echo_cur;
            case (state_q)
                S_IDLE: begin
                    trig_d = '0;
                    if (en) begin
                        t_d     = '0;
                        trig_d  = onehot(sel_q);
                        state_d = S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (t_q >= TRIG_LAST) begin
                        trig_d  = '0;
                        t_d     = '0;
                        state_d = S_WAIT_H;
                    end else begin
                        t_d = t_q + 17'd1;
                    end
                end
                S_WAIT_H: begin
                    // Only a 0->1 transition counts; a line already high is ignored.
                    if (!ep_q && echo_cur) begin
                        w_d     = '0;
                        state_d = S_MEAS;
                    end else if (t_q + 17'd1 >= TMO_T) begin
                        pub     = 1'b1;
                        pub_us  = '0;
                        pub_ok  = 1'b0;
                        t_d     = '0;
                        state_d = S_GAP;
                    end else begin
                        t_d = t_q + 17'd1;
                    end
                end
                S_MEAS: begin
                    if (echo_cur) begin
                        if (w_q + 17'd1 >= TMO_T) begin
                            pub     = 1'b1;
                            pub_us  = sat_us(w_q + 17'd1);
                            pub_ok  = 1'b0;
                            t_d     = '0;
                            state_d = S_GAP;
                        end else begin
                            w_d = w_q + 17'd1;
                        end
                    end else begin
                        pub     = 1'b1;
                        pub_us  = sat_us(w_q);
                        pub_ok  = 1'b1;
                        t_d     = '0;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    trig_d = '0;
                    if (t_q + 17'd1 >= GAP_T) begin
                        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                        t_d   = '0;
                        if (en) begin
                            trig_d  = onehot(sel_d);
                            state_d = S_TRIG;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        t_d = t_q + 17'd1;
                    end
                end
                default: begin
                    trig_d  = '0;
                    state_d = S_IDLE;
                end
            endcase
        end

        // Result registers and the near bit of the slot's own sensor.
        if (pub) begin
            mv_d          = 1'b1;
            mid_d         = sel_q;
            mus_d         = pub_us;
            mok_d         = pub_ok;
            near_d[sel_q] = is_near(pub_ok, pub_us);
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears everything, trig_out included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= S_IDLE;
            sel_q   <= '0;
            t_q     <= '0;
            w_q     <= '0;
            ep_q    <= 1'b0;
            trig_q  <= '0;
            mv_q    <= 1'b0;
            mid_q   <= '0;
            mus_q   <= '0;
            mok_q   <= 1'b0;
            near_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            sel_q   <= sel_d;
            t_q     <= t_d;
            w_q     <= w_d;
            ep_q    <= ep_d;
            trig_q  <= trig_d;
            mv_q    <= mv_d;
            mid_q   <= mid_d;
            mus_q   <= mus_d;
            mok_q   <= mok_d;
            near_q  <= near_d;
            busy_q  <= busy_d;
        end
    end

    assign trig_out   = trig_q;
    assign meas_valid = mv_q;
    assign meas_id    = mid_q;
    assign meas_us    = mus_q;
    assign meas_ok    = mok_q;
    assign near_mask  = near_q;
    assign busy       = busy_q;

endmodule
